// File: rtl/div16bits_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake,
// quotient/remainder plus an explicit divide-by-zero flag.
module div16bits_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] sourceA,
   input  logic [WIDTH-1:0] sourceB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] qacc_q, qacc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   p_c;
   logic [WIDTH:0]   trial_c;

   // State and datapath registers; reset abandons any iteration in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dividend_q  <= '0;
         divisor_q   <= '0;
         prem_q      <= '0;
         qacc_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         prem_q      <= prem_d;
         qacc_q      <= qacc_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic; busy/done are decoded from the next state so they register cleanly.
   always_comb begin
      state_d     = state_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      prem_d      = prem_q;
      qacc_d      = qacc_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      p_c         = '0;
      trial_c     = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (sourceB == '0) begin
                  quotient_d  = '1;
                  remainder_d = sourceA;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
                  done_d      = 1'b1;
               end else begin
                  dividend_d = sourceA;
                  divisor_d  = sourceB;
                  prem_d     = '0;
                  qacc_d     = '0;
                  cnt_d      = '0;
                  dbz_d      = 1'b0;
                  state_d    = S_CALC;
                  busy_d     = 1'b1;
               end
            end
         end

         S_CALC: begin
            // Bring down the next dividend bit and try subtracting the divisor.
            p_c        = {prem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
            trial_c    = p_c - {1'b0, divisor_q};
            dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
            if (!trial_c[WIDTH]) begin
               prem_d = trial_c;
               qacc_d = {qacc_q[WIDTH-2:0], 1'b1};
            end else begin
               prem_d = p_c;
               qacc_d = {qacc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               quotient_d  = qacc_d;
               remainder_d = prem_d[WIDTH-1:0];
               state_d     = S_DONE;
               done_d      = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16bits_seq.sv
// Scoreboard bench for div16bits_seq: driver pushes reference results, a monitor checks
// every done pulse for values and latency.
module tb_div16bits_seq;

   localparam int unsigned W = 16;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] sourceA = '0;
   logic [W-1:0] sourceB = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   div16bits_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .sourceA(sourceA), .sourceB(sourceB),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer division, divide-by-zero convention.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.z   = (b == 0);
      e.q   = e.z ? {W{1'b1}} : a / b;
      e.r   = e.z ? a : a % b;
      e.lat = e.z ? 1 : W + 1;
      e.acc = 0;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         chk("done_single_cycle", 32'(prev_done), 0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
      prev_done <= done;
   end

   // Present a request at a negedge into an idle DUT; record expectation after the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t e;
      @(negedge clk);
      start   = 1'b1;
      sourceA = a;
      sourceB = b;
      @(posedge clk);
      #1;
      if (push) begin
         e     = model(a, b);
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   // Wait for done (bounded), counting busy cycles; optionally poke start while busy.
   task automatic wait_done(input int exp_busy, input bit drop, input bit poke);
      int n = 0;
      int busy_n = 0;
      bit got = 0;
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (n == 1 && drop) begin
            start   = 1'b0;
            sourceA = W'($urandom);
            sourceB = W'($urandom);
         end
         if (poke && n == 3) begin
            start   = 1'b1;
            sourceA = W'(9);
            sourceB = W'(2);
         end
         if (poke && n == 4) begin
            start   = 1'b0;
            sourceA = W'($urandom);
            sourceB = W'($urandom);
         end
         if (done) got = 1;
         else if (busy) busy_n++;
      end
      chk("done_seen", 32'(got), 1);
      chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
      @(negedge clk);
      chk("done_dropped", 32'(done), 0);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
      issue(a, b, 1'b1);
      wait_done((b == 0) ? 0 : W, 1'b1, 1'b0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_q", 32'(quotient), 0);
      chk("rst_r", 32'(remainder), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      reset = 1'b0;

      run(16'd100, 16'd7);
      run(16'd65535, 16'd1);
      run(16'd65535, 16'd65535);
      run(16'd5, 16'd9);
      run(16'd0, 16'd3);
      run(16'd1234, 16'd0);
      run(16'd10, 16'd3);

      // Start pulses and operand changes while busy are ignored.
      issue(16'd40000, 16'd123, 1'b1);
      wait_done(W, 1'b1, 1'b1);

      // Start held high: re-accept on the edge after DONE returns to IDLE.
      issue(16'd50, 16'd5, 1'b1);
      wait_done(W, 1'b0, 1'b0);
      chk("held_idle_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e     = model(16'd50, 16'd5);
         e.acc = cyc;
         sb.push_back(e);
      end
      wait_done(W, 1'b1, 1'b0);

      // Reset at the 8th CALC edge abandons the division.
      issue(16'd30000, 16'd7, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_q", 32'(quotient), 0);
      chk("midrst_r", 32'(remainder), 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      run(16'd1000, 16'd10);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            2:       rb = ra;
            default: rb = W'($urandom);
         endcase
         run(ra, rb);
      end

      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
